reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port register file for the multi-cycle core. Generalises the 2R/1W reg_file:
//  - NREAD read ports and 2 write ports.
//  - Hardwired-zero option for register 0.
//  - Post-reset clear sweep FSM, so every register reads zero after reset.
//  - Per-register busy scoreboard for the multi-cycle control unit.
//  Sits between decode (read addresses) and writeback (write ports) in the datapath.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   6   address width; DEPTH = 2**ADDR_W entries
//  NREAD    2   number of read ports (1..4)
//  ZERO_REG 1   1: entry 0 reads 0, ignores writes, is never busy; 0: entry 0 is ordinary
// PORTS
//  clk        in   1               clock; all state updates on rising edge
//  rst        in   1               synchronous, active-high reset
//  rs         in   NREAD*ADDR_W    read addresses; port k = rs[k*ADDR_W +: ADDR_W]
//  rdata      out  NREAD*DATA_W    read data; port k = rdata[k*DATA_W +: DATA_W]
//  rbusy      out  NREAD           scoreboard busy bit of the entry addressed by read port k
//  we0        in   1               write enable, port 0
//  wa0        in   ADDR_W          write address, port 0
//  wd0        in   DATA_W          write data, port 0
//  we1        in   1               write enable, port 1 (priority port)
//  wa1        in   ADDR_W          write address, port 1
//  wd1        in   DATA_W          write data, port 1
//  alloc_en   in   1               mark entry alloc_addr busy (destination allocated)
//  alloc_addr in   ADDR_W          entry to mark busy
//  ready      out  1               1 = sweep finished, file accepts writes/allocs
// BEHAVIOUR
//  Reset and clear sweep:
//  - rst high at an edge: state<=CLEAR, ptr<=0, ready<=0, all busy bits<=0.
//  - Register contents are not reset directly; they are zeroed by the sweep.
//  - FSM states: CLEAR and RUN.
//  - CLEAR: each edge with rst low writes 0 to entry ptr and increments ptr.
//  - CLEAR exits on the edge that clears ptr==DEPTH-1: state<=RUN, ready<=1.
//  - ready therefore rises DEPTH (64) edges after rst deasserts.
//  - In CLEAR: we0/we1/alloc_en are ignored; rdata=0, rbusy=0 on all ports.
//  - rst asserted in RUN or mid-sweep restarts the sweep from ptr=0, clearing busy bits.
//  Reads (RUN state):
//  - Combinational, zero-cycle latency: rdata_k = mem[rs_k].
//  - With ZERO_REG=1, rs_k==0 gives 0.
//  Writes (RUN state):
//  - Registered; the value is visible on reads the cycle after the edge.
//  - we0 && we1 with wa0==wa1: port 1 data is stored, port 0 is dropped.
//  - Different addresses: both are stored in the same cycle.
//  - ZERO_REG=1: writes to address 0 are discarded.
//  Scoreboard (RUN state):
//  - alloc_en sets busy[alloc_addr].
//  - An enabled write on either port clears busy[wa].
//  - Same-edge alloc and write to the same address: alloc wins, the entry stays busy.
//  - rbusy_k = busy[rs_k], combinational.
//  - ZERO_REG=1: busy[0] is constant 0.
//  Widths:
//  - No arithmetic; ptr is ADDR_W+1 bits so the DEPTH terminal count is exact.
// CONFIGURATION
//  RF_BYPASS_EN defined: write-through forwarding.
//  - If read port k address matches an enabled same-cycle write, rdata_k returns that write
//    data (port 1 over port 0), and rbusy_k=0 unless alloc targets the same address that cycle.
//  - Still gated by ZERO_REG and by state==RUN.
//  RF_BYPASS_EN undefined:
//  - Reads return only the stored value; same-cycle writes appear the next cycle.
// TESTING
//  1. Reset then sweep:
//     - Pulse rst 1 cycle, poll ready -> ready=0 for 63 edges, 1 on the 64th.
//     - Then every rs=0..63 reads 0 and rbusy=0.
//  2. Basic write/read:
//     - we0=1, wa0=20, wd0=32'h12345678 for 1 edge.
//     - rs[0]=20 -> rdata0=32'h12345678 next cycle.
//     - Without RF_BYPASS_EN: rdata0 = old value (0) in the write cycle.
//  3. Dual-write conflict:
//     - wa0=wa1=18, wd0=32'hAAAA0000, wd1=32'h87654321 -> entry 18 reads 32'h87654321.
//     - Same edge, wa0=5 with wa1=6 -> both entries written.
//  4. Zero register:
//     - ZERO_REG=1, write 32'hFFFFFFFF to address 0 -> rdata=0.
//     - alloc_addr=0 -> rbusy=0.
//     - With ZERO_REG=0, the same write reads back 32'hFFFFFFFF.
//  5. Scoreboard:
//     - alloc_addr=7 -> rbusy for rs=7 is 1.
//     - A later we1 to wa1=7 -> rbusy=0 next cycle.
//     - alloc and write to 7 on the same edge -> rbusy stays 1.
//  6. Mid-run reset and bypass:
//     - Write 32'h12345678 to 20, then rst -> entry 20 reads 0; ready is low for 64 edges; writes during CLEAR are dropped.
//     - With RF_BYPASS_EN: in RUN, rs[1]=9 with a same-cycle write of 32'hDEADBEEF to 9 -> rdata1=32'hDEADBEEF combinationally.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with NREAD combinational read ports,
// two registered write ports (port 1 has priority), optional hardwired-zero
// entry 0, a post-reset clear sweep and a per-entry busy scoreboard.
// Optional feature macro: RF_BYPASS_EN (write-through forwarding on reads).
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREAD*ADDR_W-1:0]   rs,
    output logic [NREAD*DATA_W-1:0]   rdata,
    output logic [NREAD-1:0]          rbusy,
    input  logic                      we0,
    input  logic [ADDR_W-1:0]         wa0,
    input  logic [DATA_W-1:0]         wd0,
    input  logic                      we1,
    input  logic [ADDR_W-1:0]         wa1,
    input  logic [DATA_W-1:0]         wd1,
    input  logic                      alloc_en,
    input  logic [ADDR_W-1:0]         alloc_addr,
    output logic                      ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q;
    logic                ready_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                wr0_ok, wr1_ok;

    // Next-state logic: the sweep hands over to RUN once the last entry is cleared
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (ptr_q == LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    // State register, sweep pointer and ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                ptr_q <= ptr_q + (ADDR_W+1)'(1);
                if (ptr_q == LAST) ready_q <= 1'b1;
            end
        end
    end

    assign ready = ready_q;

    // Write qualification: port 1 wins an address collision, entry 0 may be read-only
    always_comb begin
        wr1_ok = we1 && !((ZERO_REG != 0) && (wa1 == '0));
        wr0_ok = we0 && !((ZERO_REG != 0) && (wa0 == '0)) && !(we1 && (wa1 == wa0));
    end

    // Storage: zeroed one entry per cycle during the sweep, written by both ports in RUN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[ptr_q[ADDR_W-1:0]] <= '0;
            end else begin
                if (wr0_ok) mem[wa0] <= wd0;
                if (wr1_ok) mem[wa1] <= wd1;
            end
        end
    end

    // Scoreboard update: writes retire an entry, a same-edge allocation overrides the retire
    always_comb begin
        busy_d = busy_q;
        if (we0)      busy_d[wa0]        = 1'b0;
        if (we1)      busy_d[wa1]        = 1'b0;
        if (alloc_en) busy_d[alloc_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    // Scoreboard register, cleared on reset and frozen during the sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else if (state_q == RUN) begin
            busy_q <= busy_d;
        end
    end

    // Read ports: combinational lookup, forced to zero outside RUN and for hardwired entry 0
    always_comb begin : read_ports
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;
        rdata = '0;
        rbusy = '0;
        a     = '0;
        d     = '0;
        b     = 1'b0;
        for (int unsigned k = 0; k < NREAD; k++) begin
            a = rs[k*ADDR_W +: ADDR_W];
            d = mem[a];
            b = busy_q[a];
`ifdef RF_BYPASS_EN
            if (we0 && (wa0 == a)) begin
                d = wd0;
                b = 1'b0;
            end
            if (we1 && (wa1 == a)) begin
                d = wd1;
                b = 1'b0;
            end
            if (alloc_en && (alloc_addr == a)) b = 1'b1;
`endif
            if ((state_q != RUN) || ((ZERO_REG != 0) && (a == '0))) begin
                d = '0;
                b = 1'b0;
            end
            rdata[k*DATA_W +: DATA_W] = d;
            rbusy[k] = b;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp. Stimulus pushes expected
// values into a queue; a monitor on the falling edge pops and compares them.
// Two instances share stimulus: ZERO_REG=1 (main) and ZERO_REG=0 (entry 0 ordinary).
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 2;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // kinds: 0 rdata A, 1 rbusy A, 2 ready A, 3 rdata B, 4 rbusy B, 5 ready B
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] exp;
    } chk_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rs;
    logic              we0, we1, alloc_en;
    logic [AW-1:0]     wa0, wa1, alloc_addr;
    logic [DW-1:0]     wd0, wd1;
    logic [NR*DW-1:0]  rdata_a, rdata_b;
    logic [NR-1:0]     rbusy_a, rbusy_b;
    logic              ready_a, ready_b;

    chk_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .rs(rs), .rdata(rdata_a), .rbusy(rbusy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ready(ready_a)
    );

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rs(rs), .rdata(rdata_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .ready(ready_b)
    );

    function automatic logic [31:0] actual(int kind, int port);
        case (kind)
            0:       return rdata_a[port*DW +: DW];
            1:       return {31'b0, rbusy_a[port]};
            2:       return {31'b0, ready_a};
            3:       return rdata_b[port*DW +: DW];
            4:       return {31'b0, rbusy_b[port]};
            default: return {31'b0, ready_b};
        endcase
    endfunction

    // Monitor: every falling edge, compare all expectations queued this cycle
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        while (q.size() > 0) begin
            c   = q.pop_front();
            act = actual(c.kind, c.port);
            tests++;
            if (act !== c.exp) begin
                fails++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_v(input string name, input int kind, input int port,
                            input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.port = port;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input int k, input logic [AW-1:0] a);
        rs[k*AW +: AW] = a;
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        rs  = '0;
        idle();

        // 1. reset pulse, then ready rises on the 64th edge; outputs zero during sweep
        step();
        rst = 1'b0;
        expect_v("ready_after_rst", 2, 0, 32'd0);
        expect_v("rdata_in_clear", 0, 0, 32'd0);
        for (int i = 1; i <= 64; i++) begin
            step();
            expect_v("sweep_ready", 2, 0, (i == 64) ? 32'd1 : 32'd0);
        end
        expect_v("sweep_ready_b", 5, 0, 32'd1);
        for (int a = 0; a < 64; a++) begin
            step();
            set_rs(0, AW'(a));
            set_rs(1, AW'(63 - a));
            expect_v("swept_rdata0", 0, 0, 32'd0);
            expect_v("swept_rbusy0", 1, 0, 32'd0);
            expect_v("swept_rdata1", 0, 1, 32'd0);
            expect_v("swept_rdata_b", 3, 0, 32'd0);
        end

        // 2. basic write/read
        step();
        we0 = 1'b1; wa0 = 6'd20; wd0 = 32'h12345678;
        set_rs(0, 6'd20);
        expect_v("wr_cycle_rdata", 0, 0, BYP ? 32'h12345678 : 32'd0);
        step();
        idle();
        expect_v("wr_next_rdata", 0, 0, 32'h12345678);
        expect_v("wr_next_rbusy", 1, 0, 32'd0);

        // 3. dual-write conflict, then two distinct addresses
        step();
        we0 = 1'b1; wa0 = 6'd18; wd0 = 32'hAAAA0000;
        we1 = 1'b1; wa1 = 6'd18; wd1 = 32'h87654321;
        set_rs(0, 6'd18);
        expect_v("conflict_cycle", 0, 0, BYP ? 32'h87654321 : 32'd0);
        step();
        idle();
        expect_v("conflict_port1_wins", 0, 0, 32'h87654321);
        step();
        we0 = 1'b1; wa0 = 6'd5; wd0 = 32'h05050505;
        we1 = 1'b1; wa1 = 6'd6; wd1 = 32'h06060606;
        set_rs(0, 6'd5);
        set_rs(1, 6'd6);
        step();
        idle();
        expect_v("dual_wr_port0", 0, 0, 32'h05050505);
        expect_v("dual_wr_port1", 0, 1, 32'h06060606);

        // 4. zero register
        step();
        we0 = 1'b1; wa0 = 6'd0; wd0 = 32'hFFFFFFFF;
        set_rs(0, 6'd0);
        expect_v("zero_wr_cycle", 0, 0, 32'd0);
        step();
        idle();
        expect_v("zero_rdata", 0, 0, 32'd0);
        expect_v("nozero_rdata_b", 3, 0, 32'hFFFFFFFF);
        alloc_en = 1'b1; alloc_addr = 6'd0;
        expect_v("zero_alloc_cycle", 1, 0, 32'd0);
        step();
        idle();
        expect_v("zero_rbusy", 1, 0, 32'd0);
        expect_v("nozero_rbusy_b", 4, 0, 32'd1);

        // 5. scoreboard
        step();
        alloc_en = 1'b1; alloc_addr = 6'd7;
        set_rs(1, 6'd7);
        expect_v("alloc_cycle_rbusy", 1, 1, BYP ? 32'd1 : 32'd0);
        step();
        idle();
        expect_v("alloc_rbusy", 1, 1, 32'd1);
        we1 = 1'b1; wa1 = 6'd7; wd1 = 32'h00000077;
        expect_v("retire_cycle_rbusy", 1, 1, BYP ? 32'd0 : 32'd1);
        step();
        idle();
        expect_v("retire_rbusy", 1, 1, 32'd0);
        expect_v("retire_rdata", 0, 1, 32'h00000077);
        alloc_en = 1'b1; alloc_addr = 6'd7;
        we0 = 1'b1; wa0 = 6'd7; wd0 = 32'h00000070;
        expect_v("alloc_wr_cycle_rbusy", 1, 1, BYP ? 32'd1 : 32'd0);
        step();
        idle();
        expect_v("alloc_wins_rbusy", 1, 1, 32'd1);
        expect_v("alloc_wr_rdata", 0, 1, 32'h00000070);

        // 6. mid-run reset: entry 20 and busy bits cleared, writes/allocs during sweep dropped
        rst = 1'b1;
        step();
        rst = 1'b0;
        we0 = 1'b1; wa0 = 6'd30; wd0 = 32'h00000BAD;
        alloc_en = 1'b1; alloc_addr = 6'd30;
        set_rs(0, 6'd20);
        set_rs(1, 6'd30);
        expect_v("rerst_ready", 2, 0, 32'd0);
        expect_v("rerst_rdata0", 0, 0, 32'd0);
        expect_v("rerst_rbusy1", 1, 1, 32'd0);
        for (int i = 1; i <= 64; i++) begin
            step();
            expect_v("resweep_ready", 2, 0, (i == 64) ? 32'd1 : 32'd0);
            if (i == 64) idle();
        end
        expect_v("rerst_entry20", 0, 0, 32'd0);
        expect_v("clear_wr_dropped", 0, 1, 32'd0);
        expect_v("clear_alloc_dropped", 1, 1, 32'd0);
        step();
        set_rs(0, 6'd7);
        expect_v("rerst_busy7", 1, 0, 32'd0);

        // 7. same-cycle write forwarding (stored value only when forwarding is absent)
        step();
        set_rs(1, 6'd9);
        we0 = 1'b1; wa0 = 6'd9; wd0 = 32'hDEADBEEF;
        expect_v("bypass_rdata1", 0, 1, BYP ? 32'hDEADBEEF : 32'd0);
        expect_v("bypass_rbusy1", 1, 1, 32'd0);
        step();
        idle();
        expect_v("after_bypass_rdata1", 0, 1, 32'hDEADBEEF);

        step();
        step();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
